// File: rtl/lzc_iter_sched_pkg.sv
// Shared types and default geometry for the iterative leading-zero-count scheduler.
package lzc_iter_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : lzc_iter_pkg

// File: rtl/lzc_iter_sched_if.sv
// Operand/result handshake bundle between the add stage, the LZC scheduler and the normaliser.
interface lzc_iter_sched_if #(
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_zero;
  logic [WIDTH-1:0] out_mant;

  modport master (
    output flush, in_valid, in_a, out_ready,
    input  in_ready, out_valid, out_count, out_zero, out_mant
  );

  modport slave (
    input  flush, in_valid, in_a, out_ready,
    output in_ready, out_valid, out_count, out_zero, out_mant
  );
endinterface : lzc_iter_sched_if

// File: rtl/lzc_iter_sched_slice.sv
// Combinational CHUNK-bit leading-zero counter, built recursively from 2-bit cells.
module lzc_slice #(
  parameter  int CHUNK = 4,
  localparam int LW    = $clog2(CHUNK)
) (
  input  logic [CHUNK-1:0] a,
  output logic [LW-1:0]    cnt,
  output logic             valid
);

  generate
    if (CHUNK == 2) begin : g_leaf
      assign valid = |a;
      assign cnt   = ~a[1];
    end else begin : g_node
      localparam int HW = CHUNK / 2;
      logic [LW-2:0] cnt_hi, cnt_lo;
      logic          valid_hi, valid_lo;

      lzc_slice #(.CHUNK(HW)) u_hi (.a(a[CHUNK-1:HW]), .cnt(cnt_hi), .valid(valid_hi));
      lzc_slice #(.CHUNK(HW)) u_lo (.a(a[HW-1:0]),     .cnt(cnt_lo), .valid(valid_lo));

      // The upper half wins whenever it holds a one; otherwise count all of it plus the lower half.
      assign valid = valid_hi | valid_lo;
      assign cnt   = valid_hi ? {1'b0, cnt_hi} : {1'b1, cnt_lo};
    end
  endgenerate

endmodule : lzc_slice

// File: rtl/lzc_iter_sched.sv
// Iterative MSB-first leading-zero counter: one CHUNK-bit slice per clock through a single lzc_slice.
// Define NORM_SHIFT_EN to build the final sub-slice shifter that produces a normalised out_mant.
module lzc_iter_sched
  import lzc_iter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic            clock,
  input  logic            reset,
  lzc_iter_sched_if.slave io
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int LW  = $clog2(CHUNK);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_zero_q, out_zero_d;
`ifdef NORM_SHIFT_EN
  logic [WIDTH-1:0] out_mant_q, out_mant_d;
`endif

  logic [LW-1:0]    lzc_cnt;
  logic             lzc_valid;

  lzc_slice #(.CHUNK(CHUNK)) u_slice (
    .a     (sh_q[WIDTH-1 -: CHUNK]),
    .cnt   (lzc_cnt),
    .valid (lzc_valid)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_zero_d  = out_zero_q;
`ifdef NORM_SHIFT_EN
    out_mant_d  = out_mant_q;
`endif

    if (io.flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (io.in_valid) begin
          sh_d    = io.in_a;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
        SCAN: if (lzc_valid) begin
          out_count_d = cnt_q + CW'(lzc_cnt);
          out_zero_d  = 1'b0;
`ifdef NORM_SHIFT_EN
          out_mant_d  = sh_q << lzc_cnt;
`endif
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (idx_q == IW'(NCH - 1)) begin
          cnt_d       = CW'(WIDTH);
          out_count_d = CW'(WIDTH);
          out_zero_d  = 1'b1;
`ifdef NORM_SHIFT_EN
          out_mant_d  = '0;
`endif
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(CHUNK);
          sh_d  = sh_q << CHUNK;
          idx_d = idx_q + IW'(1);
        end
        DONE: if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_zero_q  <= 1'b0;
`ifdef NORM_SHIFT_EN
      out_mant_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_zero_q  <= out_zero_d;
`ifdef NORM_SHIFT_EN
      out_mant_q  <= out_mant_d;
`endif
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.out_count = out_count_q;
  assign io.out_zero  = out_zero_q;
`ifdef NORM_SHIFT_EN
  assign io.out_mant  = out_mant_q;
`else
  assign io.out_mant  = '0;
`endif

endmodule : lzc_iter_sched
